// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the five-stage RISC-V pipeline hazard logic.
//   - Forward-select encodings for the E-stage operand multiplexers.
//   - ResultSrc encoding that identifies a load.
//   - Hazard-controller FSM state type.
//   - Shadow pipeline-register structs kept by the hazard controller.
// ----------------------------------------------------------------------------
package riscv_pkg;

    // E-stage operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in M
    localparam logic [1:0] FWD_WB  = 2'b01;  // result sitting in W

    // ResultSrc value produced by the control unit for loads.
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // Memory-wait sequencing.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } hz_state_e;

    // Shadow of the E pipeline register. All-zero is a bubble.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
        logic       mem_access;
    } e_stage_t;

    // Shadow of the M pipeline register. All-zero is a bubble.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_access;
    } m_stage_t;

    // Shadow of the W pipeline register. Only the forwarding fields are
    // needed here: once an access has left M it no longer involves memory.
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } w_stage_t;

    // An instruction touches data memory if it loads or stores.
    function automatic logic is_mem_access(input logic [1:0] result_src,
                                           input logic       mem_write);
        return (result_src == RESULT_LOAD) || mem_write;
    endfunction

endpackage : riscv_pkg

// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath/control unit (master) and the hazard
// controller (slave).
//   master drives : D-stage decode info, pc_src_e, mem_ready
//   slave drives  : stall_*, flush_*, forward_*_e, mem_req_m, mem_fault
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;

    // D-stage instruction information
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       use_rs1_d;
    logic       use_rs2_d;
    logic [4:0] rd_d;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       mem_write_d;

    // Events from E and from data memory
    logic       pc_src_e;
    logic       mem_ready;

    // Controls back to the pipeline
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       stall_w;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       mem_req_m;
    logic       mem_fault;

    modport master (
        output rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, reg_write_d,
               result_src_d, mem_write_d, pc_src_e, mem_ready,
        input  stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e,
               forward_a_e, forward_b_e, mem_req_m, mem_fault
    );

    modport slave (
        input  rs1_d, rs2_d, use_rs1_d, use_rs2_d, rd_d, reg_write_d,
               result_src_d, mem_write_d, pc_src_e, mem_ready,
        output stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e,
               forward_a_e, forward_b_e, mem_req_m, mem_fault
    );

endinterface : pipeline_hazard_ctrl_if

// File: rtl/hazard_fwd_sel.sv
// ----------------------------------------------------------------------------
// hazard_fwd_sel
// Forward-select logic for one E-stage source operand.
//   rs_e        in  5  source register of the instruction in E
//   rd_m        in  5  destination of the instruction in M
//   reg_write_m in  1  M instruction writes the register file
//   rd_w        in  5  destination of the instruction in W
//   reg_write_w in  1  W instruction writes the register file
//   fwd_sel     out 2  FWD_MEM / FWD_WB / FWD_RF
// M wins over W because it holds the younger value; x0 never forwards since
// it is hard-wired to zero in the register file.
// ----------------------------------------------------------------------------
module hazard_fwd_sel
    import riscv_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule : hazard_fwd_sel

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the five-stage RISC-V pipeline.
// Keeps shadow copies of the E/M/W control fields and derives from them:
//   - operand forwarding selects for E,
//   - load-use stalls (one bubble),
//   - taken-branch/jump flushes (two bubbles),
//   - a whole-pipeline freeze while data memory has not acknowledged,
//   - a sticky fault when memory never answers within TIMEOUT cycles.
// Ports:
//   clock    in  pipeline clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   hz       slave side of pipeline_hazard_ctrl_if (D info, pc_src_e,
//            mem_ready in; stalls, flushes, forwards, mem_req_m, mem_fault out)
// Parameters:
//   TIMEOUT  wait cycles tolerated before mem_fault
//   WAIT_W   wait counter width, 2**WAIT_W > TIMEOUT
// All outputs are combinational from inputs and shadow state.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int WAIT_W  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    pipeline_hazard_ctrl_if.slave  hz
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] CNT_MAX     = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    e_stage_t          e_q, e_d;
    m_stage_t          m_q, m_d;
    w_stage_t          w_q, w_d;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic mem_req;
    logic freeze;
    logic stall_all;
    logic lw_hazard;
    logic lw_stall;
    logic branch_flush;

    always_comb begin
        mem_req   = m_q.mem_access && (state_q != ST_FAULT);
        freeze    = mem_req && !hz.mem_ready;
        // A fault keeps the pipeline frozen until reset.
        stall_all = freeze || (state_q == ST_FAULT);

        lw_hazard = e_q.is_load && (e_q.rd != 5'd0) &&
                    ((hz.use_rs1_d && (hz.rs1_d == e_q.rd)) ||
                     (hz.use_rs2_d && (hz.rs2_d == e_q.rd)));

        // Priority: freeze > branch > load-use. A branch seen during a freeze
        // is not lost: E is held, so pc_src_e reappears on release.
        branch_flush = hz.pc_src_e && !stall_all;
        lw_stall     = lw_hazard && !hz.pc_src_e && !stall_all;
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    hazard_fwd_sel u_fwd_a (
        .rs_e        (e_q.rs1),
        .rd_m        (m_q.rd),
        .reg_write_m (m_q.reg_write),
        .rd_w        (w_q.rd),
        .reg_write_w (w_q.reg_write),
        .fwd_sel     (hz.forward_a_e)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_e        (e_q.rs2),
        .rd_m        (m_q.rd),
        .reg_write_m (m_q.reg_write),
        .rd_w        (w_q.rd),
        .reg_write_w (w_q.reg_write),
        .fwd_sel     (hz.forward_b_e)
    );

    // ------------------------------------------------------------------
    // Pipeline controls
    // ------------------------------------------------------------------
    assign hz.stall_f   = stall_all || lw_stall;
    assign hz.stall_d   = stall_all || lw_stall;
    assign hz.stall_e   = stall_all;
    assign hz.stall_m   = stall_all;
    // W is held rather than bubbled so its forwarding value survives a freeze.
    assign hz.stall_w   = stall_all;
    assign hz.flush_d   = branch_flush;
    assign hz.flush_e   = branch_flush || lw_stall;
    assign hz.mem_req_m = mem_req;
    assign hz.mem_fault = (state_q == ST_FAULT);

    // ------------------------------------------------------------------
    // Shadow stage next-state
    // ------------------------------------------------------------------
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;

        if (!stall_all) begin
            if (branch_flush || lw_stall) begin
                e_d = '0;
            end else begin
                e_d = '{rs1:        hz.rs1_d,
                        rs2:        hz.rs2_d,
                        rd:         hz.rd_d,
                        reg_write:  hz.reg_write_d,
                        is_load:    (hz.result_src_d == RESULT_LOAD),
                        mem_access: is_mem_access(hz.result_src_d, hz.mem_write_d)};
            end
            m_d = '{rd: e_q.rd, reg_write: e_q.reg_write, mem_access: e_q.mem_access};
            w_d = '{rd: m_q.rd, reg_write: m_q.reg_write};
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM and wait counter
    // ------------------------------------------------------------------
    // The counter tallies not-ready cycles, starting with the RUN cycle in
    // which the freeze first appears. When it already equals TIMEOUT and
    // memory is still not ready, that cycle is number TIMEOUT+1 and the
    // controller gives up.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            ST_RUN, ST_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q >= TIMEOUT_CNT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q
                                                             : wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                // ST_FAULT is terminal until reset.
                state_d = ST_FAULT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge, independent of statement order.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            e_q        <= e_d;
            m_q        <= m_d;
            w_q        <= w_d;
        end
    end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl (TIMEOUT = 4). The bench plays the
// role of the datapath: it presents one D-stage instruction per cycle and
// holds D while stall_d is expected. Inputs change 2 ns after the rising
// edge and outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import riscv_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .TIMEOUT (4),
        .WAIT_W  (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz.slave)
    );

    // {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}
    localparam logic [6:0] CTL_NONE = 7'b00000_00;
    localparam logic [6:0] CTL_LW   = 7'b11000_01;
    localparam logic [6:0] CTL_BR   = 7'b00000_11;
    localparam logic [6:0] CTL_ALL  = 7'b11111_00;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check({tag, ".ctl"},
              {9'd0, hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.stall_w,
               hz.flush_d, hz.flush_e},
              {9'd0, exp});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] fa, input logic [1:0] fb);
        check({tag, ".fwd"}, {12'd0, hz.forward_a_e, hz.forward_b_e}, {12'd0, fa, fb});
    endtask

    task automatic check_mem(input string tag, input logic req, input logic fault);
        check({tag, ".mem"}, {14'd0, hz.mem_req_m, hz.mem_fault}, {14'd0, req, fault});
    endtask

    task automatic set_d(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd,  input logic rw,
                         input logic [1:0] rsrc, input logic mw);
        hz.rs1_d        = rs1;
        hz.use_rs1_d    = u1;
        hz.rs2_d        = rs2;
        hz.use_rs2_d    = u2;
        hz.rd_d         = rd;
        hz.reg_write_d  = rw;
        hz.result_src_d = rsrc;
        hz.mem_write_d  = mw;
    endtask

    task automatic set_nop();
        set_d(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        reset_n      = 1'b1;
        hz.pc_src_e  = 1'b0;
        hz.mem_ready = 1'b1;
        set_nop();
        #1 reset_n = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clock);
        #2;
        check_ctl("reset", CTL_NONE);
        check_fwd("reset", 2'b00, 2'b00);
        check_mem("reset", 1'b0, 1'b0);
        reset_n = 1'b1;

        // ---------------- forwarding ----------------
        set_d(5'd1, 1, 5'd2, 1, 5'd5, 1, 2'b00, 0);   // add x5, x1, x2
        tick();
        set_d(5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b00, 0);   // add x5, x5, x0
        #1 check_fwd("fwd_none", 2'b00, 2'b00);
        tick();
        set_d(5'd5, 1, 5'd5, 1, 5'd8, 1, 2'b00, 0);   // add x8, x5, x5
        #1 check_fwd("fwd_m", 2'b10, 2'b00);
        tick();
        set_d(5'd5, 1, 5'd8, 1, 5'd0, 1, 2'b00, 0);   // add x0, x5, x8
        #1 check_fwd("fwd_m_over_w", 2'b10, 2'b10);
        tick();
        set_d(5'd0, 1, 5'd8, 1, 5'd9, 1, 2'b00, 0);   // add x9, x0, x8
        #1 check_fwd("fwd_w_only", 2'b01, 2'b10);
        tick();
        set_nop();
        #1 check_fwd("fwd_x0", 2'b00, 2'b01);
        check_ctl("fwd_x0", CTL_NONE);
        tick();

        // ---------------- load-use ----------------
        set_d(5'd1, 1, 5'd0, 0, 5'd6, 1, RESULT_LOAD, 0);   // lw x6, 0(x1)
        #1 check_ctl("pre_lw", CTL_NONE);
        tick();
        set_d(5'd2, 1, 5'd6, 1, 5'd9, 1, 2'b00, 0);   // add x9, x2, x6
        #1 check_ctl("lw_stall", CTL_LW);
        tick();
        #1 check_ctl("lw_one_bubble", CTL_NONE);      // D held by the bench
        check_fwd("lw_bubble", 2'b00, 2'b00);
        tick();
        set_nop();
        #1 check_fwd("lw_fwd_wb", 2'b00, 2'b01);
        tick();
        set_d(5'd1, 1, 5'd0, 0, 5'd6, 1, RESULT_LOAD, 0);   // lw x6, 0(x1)
        tick();
        set_d(5'd2, 1, 5'd6, 0, 5'd9, 1, 2'b00, 0);   // rs2 = x6 but not read
        #1 check_ctl("lw_unused_src", CTL_NONE);
        tick();

        // ---------------- branch ----------------
        set_d(5'd1, 1, 5'd0, 0, 5'd11, 1, RESULT_LOAD, 0);  // lw x11, 0(x1)
        tick();
        set_d(5'd11, 1, 5'd0, 0, 5'd12, 1, 2'b00, 0); // add x12, x11 (load-use)
        hz.pc_src_e = 1'b1;
        #1 check_ctl("br_over_lw", CTL_BR);
        tick();
        hz.pc_src_e = 1'b0;
        set_d(5'd12, 1, 5'd0, 0, 5'd13, 1, 2'b00, 0); // add x13, x12
        #1 check_ctl("br_one_cycle", CTL_NONE);
        tick();
        set_nop();
        #1 check_fwd("br_bubble", 2'b00, 2'b00);      // flushed x12 must not forward
        tick();

        // ---------------- memory wait ----------------
        set_d(5'd1, 1, 5'd2, 1, 5'd0, 0, 2'b00, 1);   // sw x2, 0(x1)
        #1 check_mem("pre_sw", 1'b0, 1'b0);
        tick();
        set_nop();
        #1 check_mem("sw_in_e", 1'b0, 1'b0);
        tick();
        hz.mem_ready = 1'b0;
        #1 check_ctl("wait1", CTL_ALL);
        check_mem("wait1", 1'b1, 1'b0);
        tick();
        hz.pc_src_e = 1'b1;                           // branch arrives during freeze
        #1 check_ctl("wait2_br_held", CTL_ALL);
        check_mem("wait2", 1'b1, 1'b0);
        tick();
        #1 check_ctl("wait3", CTL_ALL);
        check_mem("wait3", 1'b1, 1'b0);
        tick();
        hz.mem_ready = 1'b1;
        #1 check_ctl("release_br", CTL_BR);
        check_mem("release", 1'b1, 1'b0);
        tick();
        hz.pc_src_e = 1'b0;
        #1 check_ctl("run_again", CTL_NONE);
        check_mem("run_again", 1'b0, 1'b0);
        tick();

        // ---------------- timeout ----------------
        set_d(5'd1, 1, 5'd0, 0, 5'd14, 1, RESULT_LOAD, 0);  // lw x14, 0(x1)
        tick();
        set_nop();
        tick();                                       // lw enters M
        hz.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 check_ctl($sformatf("to_wait%0d", i), CTL_ALL);
            check_mem($sformatf("to_wait%0d", i), 1'b1, 1'b0);
            tick();
        end
        #1 check_ctl("fault", CTL_ALL);
        check_mem("fault", 1'b0, 1'b1);
        hz.mem_ready = 1'b1;
        hz.pc_src_e  = 1'b1;
        tick();
        #1 check_ctl("fault_sticky", CTL_ALL);
        check_mem("fault_sticky", 1'b0, 1'b1);
        hz.pc_src_e = 1'b0;
        reset_n = 1'b0;
        #1 check_mem("rst_fault", 1'b0, 1'b0);
        check_ctl("rst_fault", CTL_NONE);
        reset_n = 1'b1;
        tick();

        // ---------------- reset during WAIT ----------------
        set_d(5'd1, 1, 5'd2, 1, 5'd0, 0, 2'b00, 1);   // sw x2, 0(x1)
        tick();
        set_nop();
        tick();
        hz.mem_ready = 1'b0;
        #1 check_ctl("rw_wait1", CTL_ALL);
        tick();
        #1 check_ctl("rw_wait2", CTL_ALL);
        reset_n = 1'b0;
        #1 check_ctl("rst_in_wait", CTL_NONE);
        check_fwd("rst_in_wait", 2'b00, 2'b00);
        check_mem("rst_in_wait", 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        #1 check_ctl("after_rst", CTL_NONE);
        check_mem("after_rst", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
